// File: rtl/caf_pkg.sv
// Shared types for the CAF lag-sweep datapath.
// FSM state encoding and the |p|^2 width helper.
package caf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    function automatic int mag_bits(input int ib, input int qb);
        return ((ib > qb) ? 2 * ib : 2 * qb) + 1;
    endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// Combinational |p|^2 of a signed complex sample.
// Squares are exact and the sum carries one extra bit.
module cpx_mag_sq
    import caf_pkg::*;
#(
    parameter int I_BITS = 24,
    parameter int Q_BITS = 24,
    localparam int MAG_BITS = mag_bits(I_BITS, Q_BITS)
) (
    input  logic signed [I_BITS-1:0] re_i,
    input  logic signed [Q_BITS-1:0] im_i,
    output logic [MAG_BITS-1:0]      mag_o
);

    logic signed [2*I_BITS-1:0] re_x;
    logic signed [2*I_BITS-1:0] re_sq;
    logic signed [2*Q_BITS-1:0] im_x;
    logic signed [2*Q_BITS-1:0] im_sq;

    assign re_x  = (2*I_BITS)'(re_i);
    assign im_x  = (2*Q_BITS)'(im_i);
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    assign mag_o = MAG_BITS'($unsigned(re_sq))
                 + MAG_BITS'($unsigned(im_sq));

endmodule

// File: rtl/dot_prod_sched.sv
// Lag-sweep scheduler for the CAF dot-product engine; tracks peak |p|^2.
// Optional watchdog on the result wait: DOT_PROD_SCHED_TIMEOUT_EN.
module dot_prod_sched
    import caf_pkg::*;
#(
    parameter int I_BITS   = 24,
    parameter int Q_BITS   = 24,
    parameter int LAG_BITS = 8,
    parameter int RD_LAT   = 1,
    parameter int TIMEOUT  = 64,
    localparam int MAG_BITS = mag_bits(I_BITS, Q_BITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LAG_BITS-1:0]        num_lags,
    output logic                       busy,
    output logic [LAG_BITS-1:0]        lag_addr,
    output logic                       dp_tvalid,
    output logic                       dp_product_tready,
    input  logic                       dp_product_tvalid,
    input  logic signed [I_BITS-1:0]   dp_i,
    input  logic signed [Q_BITS-1:0]   dp_q,
    output logic                       done,
    output logic                       peak_valid,
    output logic [LAG_BITS-1:0]        peak_lag,
    output logic [MAG_BITS-1:0]        peak_mag
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
   ,output logic                       timeout_err
`endif
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

    if (RD_LAT < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("dot_prod_sched: RD_LAT and TIMEOUT must be >= 1");
    end

    state_e              state_q, state_d;
    logic [LAG_BITS-1:0] lag_q, lag_d;
    logic [LAG_BITS-1:0] nlags_q, nlags_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MAG_BITS-1:0] pmag_q, pmag_d;
    logic [LAG_BITS-1:0] plag_q, plag_d;
    logic                pval_q, pval_d;
    logic [MAG_BITS-1:0] mag;

`ifdef DOT_PROD_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          terr_q, terr_d;
`endif

    cpx_mag_sq #(
        .I_BITS (I_BITS),
        .Q_BITS (Q_BITS)
    ) u_mag (
        .re_i  (dp_i),
        .im_i  (dp_q),
        .mag_o (mag)
    );

    always_comb begin
        state_d = state_q;
        lag_d   = lag_q;
        nlags_d = nlags_q;
        cnt_d   = cnt_q;
        pmag_d  = pmag_q;
        plag_d  = plag_q;
        pval_d  = pval_q;
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
        wd_d    = wd_q;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lag_d  = '0;
                    cnt_d  = '0;
                    pmag_d = '0;
                    plag_d = '0;
                    pval_d = 1'b0;
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
                    terr_d = 1'b0;
`endif
                    if (num_lags != '0) begin
                        nlags_d = num_lags;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (cnt_q == CNT_LAST) state_d = S_ISSUE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (dp_product_tvalid) begin
                    // strict > so a tie keeps the earlier lag
                    if (lag_q == '0 || mag > pmag_q) begin
                        pmag_d = mag;
                        plag_d = lag_q;
                    end
                    if (lag_q == nlags_q - 1'b1) begin
                        pval_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        lag_d   = lag_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
                else if (wd_q == WW'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    pval_d  = (lag_q != '0);
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lag_q   <= '0;
            nlags_q <= '0;
            cnt_q   <= '0;
            pmag_q  <= '0;
            plag_q  <= '0;
            pval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lag_q   <= lag_d;
            nlags_q <= nlags_d;
            cnt_q   <= cnt_d;
            pmag_q  <= pmag_d;
            plag_q  <= plag_d;
            pval_q  <= pval_d;
        end
    end

`ifdef DOT_PROD_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`endif

    assign busy              = (state_q != S_IDLE);
    assign lag_addr          = lag_q;
    assign dp_tvalid         = (state_q == S_ISSUE);
    assign dp_product_tready = (state_q == S_WAIT);
    assign done              = (state_q == S_DONE);
    assign peak_valid        = pval_q;
    assign peak_lag          = plag_q;
    assign peak_mag          = pmag_q;

endmodule

// File: tb/tb_dot_prod_sched.sv
// Directed bench for dot_prod_sched: sweeps, ties, extremes, spurious
// inputs, mid-sweep reset and the stalled-engine case.
module tb_dot_prod_sched;
    import caf_pkg::*;

    localparam int IB = 24;
    localparam int QB = 24;
    localparam int LB = 8;
    localparam int RL = 1;
    localparam int TO = 16;
    localparam int MB = mag_bits(IB, QB);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LB-1:0]        num_lags = '0;
    logic                 busy;
    logic [LB-1:0]        lag_addr;
    logic                 dp_tvalid;
    logic                 dp_product_tready;
    logic                 dp_product_tvalid = 1'b0;
    logic signed [IB-1:0] dp_i = '0;
    logic signed [QB-1:0] dp_q = '0;
    logic                 done;
    logic                 peak_valid;
    logic [LB-1:0]        peak_lag;
    logic [MB-1:0]        peak_mag;
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
    logic                 timeout_err;
`endif

    dot_prod_sched #(
        .I_BITS   (IB),
        .Q_BITS   (QB),
        .LAG_BITS (LB),
        .RD_LAT   (RL),
        .TIMEOUT  (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_lags          (num_lags),
        .busy              (busy),
        .lag_addr          (lag_addr),
        .dp_tvalid         (dp_tvalid),
        .dp_product_tready (dp_product_tready),
        .dp_product_tvalid (dp_product_tvalid),
        .dp_i              (dp_i),
        .dp_q              (dp_q),
        .done              (done),
        .peak_valid        (peak_valid),
        .peak_lag          (peak_lag),
        .peak_mag          (peak_mag)
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
       ,.timeout_err       (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int tv_cnt = 0;
    longint vi[16];
    longint vq[16];

    always @(posedge clk) begin
        if (done)      done_cnt <= done_cnt + 1;
        if (dp_tvalid) tv_cnt   <= tv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tv(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (dp_tvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " lag_addr"}, 64'(lag_addr), 64'd0);
        chk({tag, " tvalid"}, 64'(dp_tvalid), 64'd0);
        chk({tag, " tready"}, 64'(dp_product_tready), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " pvalid"}, 64'(peak_valid), 64'd0);
        chk({tag, " plag"}, 64'(peak_lag), 64'd0);
        chk({tag, " pmag"}, 64'(peak_mag), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; vi/vq hold the per-lag results.
    task automatic sweep(input int n, input bit spur, input int rst_at,
                         input int exp_lag, input longint exp_mag,
                         input string tag);
        bit ok;
        int cyc;
        int d0;
        start    = 1'b1;
        num_lags = LB'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        chk({tag, " busy1"}, 64'(busy), 64'd1);
        chk({tag, " addr0"}, 64'(lag_addr), 64'd0);
        for (int k = 0; k < n; k++) begin
            wait_tv(ok, cyc);
            if (!ok) begin
                chk({tag, " tvalid_timeout"}, 64'd0, 64'd1);
                return;
            end
            if (k == 0) chk({tag, " issue_lat"}, 64'(cyc), 64'(RL));
            chk({tag, " lag_addr"}, 64'(lag_addr), 64'(k));
            @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals({tag, " midrst"});
                chk({tag, " midrst_nodone"}, 64'(done_cnt - d0), 64'd0);
                return;
            end
            dp_product_tvalid = 1'b1;
            dp_i = IB'(vi[k]);
            dp_q = QB'(vq[k]);
            @(negedge clk);
            dp_product_tvalid = 1'b0;
            if (spur && k != n - 1) begin
                dp_product_tvalid = 1'b1;
                dp_i = {1'b1, {(IB-1){1'b0}}};
                dp_q = {1'b1, {(QB-1){1'b0}}};
                start    = 1'b1;
                num_lags = LB'(1);
                @(negedge clk);
                dp_product_tvalid = 1'b0;
                start = 1'b0;
            end
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " busy_done"}, 64'(busy), 64'd1);
        chk({tag, " pvalid"}, 64'(peak_valid), 64'd1);
        chk({tag, " plag"}, 64'(peak_lag), 64'(exp_lag));
        chk({tag, " pmag"}, 64'(peak_mag), 64'(exp_mag));
        @(negedge clk);
        chk({tag, " done_low"}, 64'(done), 64'd0);
        chk({tag, " busy_low"}, 64'(busy), 64'd0);
        chk({tag, " one_done"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " pmag_hold"}, 64'(peak_mag), 64'(exp_mag));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        int  t0;
        bit  ok;
        int  cyc;

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // (3,4)=25 (-6,8)=100 (10,0)=100 (0,-10)=100: tie keeps lag 1
        vi[0] = 3;  vq[0] = 4;
        vi[1] = -6; vq[1] = 8;
        vi[2] = 10; vq[2] = 0;
        vi[3] = 0;  vq[3] = -10;
        sweep(4, 1'b0, -1, 1, 100, "basic");

        d0 = done_cnt;
        t0 = tv_cnt;
        start    = 1'b1;
        num_lags = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("zero done", 64'(done), 64'd1);
        chk("zero busy", 64'(busy), 64'd1);
        chk("zero pvalid", 64'(peak_valid), 64'd0);
        @(negedge clk);
        chk("zero done_low", 64'(done), 64'd0);
        chk("zero busy_low", 64'(busy), 64'd0);
        chk("zero one_done", 64'(done_cnt - d0), 64'd1);
        chk("zero no_tvalid", 64'(tv_cnt - t0), 64'd0);

        // (-2^23)^2 * 2 = 2^47
        vi[0] = -(64'sd1 <<< 23);
        vq[0] = -(64'sd1 <<< 23);
        sweep(1, 1'b0, -1, 0, 64'h8000_0000_0000, "extreme");

        // 2, 12500, 98, 12500, 13 with spurious traffic in every FETCH
        vi[0] = 1;    vq[0] = 1;
        vi[1] = -100; vq[1] = 50;
        vi[2] = 7;    vq[2] = -7;
        vi[3] = 100;  vq[3] = -50;
        vi[4] = -3;   vq[4] = 2;
        sweep(5, 1'b1, -1, 1, 12500, "spur");

        vi[0] = 0;  vq[0] = 0;
        vi[1] = 20; vq[1] = 20;
        vi[2] = 1;  vq[2] = 1;
        vi[3] = 2;  vq[3] = 2;
        sweep(4, 1'b0, 2, 0, 0, "rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 50, 5, 64
        vi[0] = 5;  vq[0] = 5;
        vi[1] = 2;  vq[1] = -1;
        vi[2] = -8; vq[2] = 0;
        sweep(3, 1'b0, -1, 2, 64, "fresh");

        d0 = done_cnt;
        start    = 1'b1;
        num_lags = LB'(1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_tv(ok, cyc);
        chk("stall issue", 64'(ok), 64'd1);
`ifdef DOT_PROD_SCHED_TIMEOUT_EN
        repeat (17) @(negedge clk);
        chk("tmo done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("tmo done", 64'(done), 64'd1);
        chk("tmo err", 64'(timeout_err), 64'd1);
        chk("tmo pvalid", 64'(peak_valid), 64'd0);
        @(negedge clk);
        chk("tmo err_sticky", 64'(timeout_err), 64'd1);
        chk("tmo busy_low", 64'(busy), 64'd0);
`else
        repeat (100) @(negedge clk);
        chk("stall busy", 64'(busy), 64'd1);
        chk("stall tready", 64'(dp_product_tready), 64'd1);
        chk("stall no_done", 64'(done_cnt - d0), 64'd0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
